radix4_mult_arbiter: RTL and testbench



---
 rtl/radix4_mult_arbiter.sv | 162 ++++++++++++++++
 tb/tb_radix4_mult_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/radix4_mult_arbiter.sv
// rtl/radix4_mult_arbiter.sv - two-requester arbiter sharing one radix-4 Booth 11x11 multiplier
//
// radix4_mult: combinational 11x11 unsigned multiplier, 22-bit product.
//   a_i  [10:0]  multiplicand
//   x_i  [10:0]  multiplier
//   p_o  [21:0]  a_i * x_i
//
// radix4_mult_arbiter: arbitrates two operand requesters onto the multiplier, registers
// operands and product, and returns the product to the requester that issued it.
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready per-requester operand handshake (bit i = requester i)
//   req_a/req_x         {a1,a0} / {x1,x0} operands
//   rsp_valid/rsp_ready per-requester product handshake
//   rsp_p               product, meaningful for the asserted rsp_valid bit
//   busy                high whenever an operation is in flight
//   op_count            completed response handshakes, wraps

module radix4_mult (
  input  logic [10:0] a_i,
  input  logic [10:0] x_i,
  output logic [21:0] p_o
);
  // x with an implicit zero below the LSB and a zero sign bit above the MSB, so
  // the Booth recoding of a signed number yields the unsigned product.
  logic [12:0] xe;
  logic [2:0]  trip;
  logic [21:0] pp;
  logic [21:0] acc;

  // All arithmetic is modulo 2^22; negative partial products wrap and cancel
  // because the true product always fits in 22 bits.
  always_comb begin
    xe   = {1'b0, x_i, 1'b0};
    trip = '0;
    pp   = '0;
    acc  = '0;
    for (int i = 0; i < 6; i++) begin
      trip = xe[2*i +: 3];
      case (trip)
        3'b001, 3'b010: pp = {11'b0, a_i};
        3'b011:         pp = {10'b0, a_i, 1'b0};
        3'b100:         pp = 22'd0 - {10'b0, a_i, 1'b0};
        3'b101, 3'b110: pp = 22'd0 - {11'b0, a_i};
        default:        pp = '0;
      endcase
      acc = acc + (pp << (2*i));
    end
    p_o = acc;
  end
endmodule

module radix4_mult_arbiter #(
  parameter int OP_W       = 11,
  parameter int FIXED_PRIO = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*OP_W-1:0] req_a,
  input  logic [2*OP_W-1:0] req_x,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [2*OP_W-1:0] rsp_p,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);
  if (OP_W != 11) begin : g_bad_op_w
    $error("radix4_mult_arbiter: OP_W must be 11");
  end

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t            state_q, state_d;
  logic [OP_W-1:0]   a_q, a_d, x_q, x_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              grant;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [2*OP_W-1:0] rsp_p_q, rsp_p_d;
  logic [2*OP_W-1:0] prod;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  radix4_mult u_mult (
    .a_i (a_q),
    .x_i (x_q),
    .p_o (prod)
  );

  // Winner among the valid requesters; only consumed when at least one is valid.
  always_comb begin
    if (FIXED_PRIO != 0)   grant = ~req_valid[0];
    else if (&req_valid)   grant = ~last_q;
    else                   grant = req_valid[1];
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    x_d         = x_q;
    owner_d     = owner_q;
    last_d      = last_q;
    rsp_valid_d = rsp_valid_q;
    rsp_p_d     = rsp_p_q;
    cnt_d       = cnt_q;
    req_ready   = '0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          // Gated by rst_n so req_ready reads zero while reset is held.
          req_ready = rst_n ? (grant ? 2'b10 : 2'b01) : 2'b00;
          a_d       = grant ? req_a[2*OP_W-1:OP_W] : req_a[OP_W-1:0];
          x_d       = grant ? req_x[2*OP_W-1:OP_W] : req_x[OP_W-1:0];
          owner_d   = grant;
          last_d    = grant;
          state_d   = CALC;
        end
      end
      CALC: begin
        rsp_p_d     = prod;
        rsp_valid_d = owner_q ? 2'b10 : 2'b01;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          rsp_valid_d = '0;
          cnt_d       = cnt_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      x_q         <= '0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      rsp_valid_q <= '0;
      rsp_p_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      x_q         <= x_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_p_q     <= rsp_p_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_p     = rsp_p_q;
  assign busy      = (state_q != IDLE);
  assign op_count  = cnt_q;
endmodule

// File: tb/tb_radix4_mult_arbiter.sv
// tb/tb_radix4_mult_arbiter.sv - self-checking bench for radix4_mult_arbiter
module tb_radix4_mult_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid [2];
  logic [1:0]  req_ready [2];
  logic [21:0] req_a     [2];
  logic [21:0] req_x     [2];
  logic [1:0]  rsp_valid [2];
  logic [1:0]  rsp_ready [2];
  logic [21:0] rsp_p     [2];
  logic        busy      [2];
  logic [15:0] op_count0;
  logic [3:0]  op_count1;

  int vectors = 0;
  int miscompares = 0;
  int last_m [2];
  int cnt_m  [2];

  always #5 clk = ~clk;

  // d0: round-robin, 16-bit counter. d1: fixed priority, 4-bit counter (wrap test).
  radix4_mult_arbiter #(.OP_W(11), .FIXED_PRIO(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_a(req_a[0]), .req_x(req_x[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_p(rsp_p[0]), .busy(busy[0]), .op_count(op_count0));
  radix4_mult_arbiter #(.OP_W(11), .FIXED_PRIO(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_a(req_a[1]), .req_x(req_x[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_p(rsp_p[1]), .busy(busy[1]), .op_count(op_count1));

  function automatic logic [15:0] count_of(input int d);
    return (d == 0) ? op_count0 : {12'b0, op_count1};
  endfunction

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 2'b00;
      rsp_ready[d] = 2'b00;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      last_m[d] = 1;
      cnt_m[d]  = 0;
    end
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // One full operation starting at a negedge with the DUT idle; ends at the negedge after the
  // response handshake. got_ready returns the req_ready seen in the request cycle.
  task automatic do_op(input int d, input logic [1:0] v, input logic [1:0] v_after,
                       input logic [10:0] a0, input logic [10:0] x0,
                       input logic [10:0] a1, input logic [10:0] x1,
                       input int stall, output logic [1:0] got_ready);
    int          g;
    logic [1:0]  oh;
    logic [21:0] expp;
    logic [15:0] expc;
    if (v == 2'b01)      g = 0;
    else if (v == 2'b10) g = 1;
    else if (d == 1)     g = 0;
    else                 g = 1 - last_m[d];
    oh   = (g == 0) ? 2'b01 : 2'b10;
    expp = (g == 0) ? 22'(a0) * 22'(x0) : 22'(a1) * 22'(x1);
    req_valid[d] = v;
    req_a[d] = {a1, a0};
    req_x[d] = {x1, x0};
    rsp_ready[d] = ~oh & 2'($urandom);
    #1;
    got_ready = req_ready[d];
    vectors++;
    if (req_ready[d] !== oh) begin
      miscompares++; $display("FAIL grant d%0d: req_ready=%b expected %b", d, req_ready[d], oh);
    end
    vectors++;
    if (busy[d] !== 1'b0) begin
      miscompares++; $display("FAIL idle_busy d%0d: busy=%b expected 0", d, busy[d]);
    end
    @(negedge clk);
    last_m[d] = g;
    req_valid[d] = v_after;
    req_a[d] = 22'($urandom);
    req_x[d] = 22'($urandom);
    #1;
    vectors++;
    if (busy[d] !== 1'b1 || rsp_valid[d] !== 2'b00 || req_ready[d] !== 2'b00) begin
      miscompares++;
      $display("FAIL calc d%0d: busy=%b rsp_valid=%b req_ready=%b expected 1/00/00",
               d, busy[d], rsp_valid[d], req_ready[d]);
    end
    @(negedge clk);
    for (int s = 0; s <= stall; s++) begin
      #1;
      vectors++;
      if (rsp_valid[d] !== oh || rsp_p[d] !== expp || req_ready[d] !== 2'b00) begin
        miscompares++;
        $display("FAIL resp d%0d cyc%0d: rsp_valid=%b rsp_p=%h req_ready=%b expected %b %h 00",
                 d, s, rsp_valid[d], rsp_p[d], req_ready[d], oh, expp);
      end
      rsp_ready[d] = (s == stall) ? (oh | 2'($urandom)) : (~oh & 2'($urandom));
      @(negedge clk);
    end
    cnt_m[d]++;
    expc = (d == 0) ? 16'(cnt_m[d]) : {12'b0, 4'(cnt_m[d])};
    #1;
    vectors++;
    if (rsp_valid[d] !== 2'b00 || busy[d] !== 1'b0 || count_of(d) !== expc) begin
      miscompares++;
      $display("FAIL done d%0d: rsp_valid=%b busy=%b op_count=%0d expected 00 0 %0d",
               d, rsp_valid[d], busy[d], count_of(d), expc);
    end
    rsp_ready[d] = 2'b00;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      for (int d = 0; d < 2; d++) begin
        req_valid[d] = 2'($urandom);
        rsp_ready[d] = 2'($urandom);
        req_a[d] = 22'($urandom);
        req_x[d] = 22'($urandom);
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (req_ready[d] !== 2'b00 || rsp_valid[d] !== 2'b00 || rsp_p[d] !== 22'd0 ||
            busy[d] !== 1'b0 || count_of(d) !== 16'd0) begin
          miscompares++;
          $display("FAIL reset_outputs d%0d: req_ready=%b rsp_valid=%b rsp_p=%h busy=%b cnt=%0d expected all 0",
                   d, req_ready[d], rsp_valid[d], rsp_p[d], busy[d], count_of(d));
        end
      end
      @(negedge clk);
    end
    idle_inputs();
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (busy[d] !== 1'b0 || req_ready[d] !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_release d%0d: busy=%b req_ready=%b expected 0 00", d, busy[d], req_ready[d]);
      end
    end
  endtask

  task automatic test_single();
    logic [1:0] r;
    idle_inputs();
    do_op(0, 2'b01, 2'b00, 11'd2047, 11'd2047, 11'd0, 11'd0, 0, r);
  endtask

  task automatic test_alternate();
    logic [1:0] r;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      do_op(0, 2'b11, 2'b11, 11'd3, 11'd5, 11'd7, 11'd9, 0, r);
      vectors++;
      if (r !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        miscompares++; $display("FAIL rr_sequence op%0d: req_ready=%b", k, r);
      end
    end
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      do_op(1, 2'b11, 2'b11, 11'd3, 11'd5, 11'd7, 11'd9, 0, r);
      vectors++;
      if (r !== 2'b01) begin
        miscompares++; $display("FAIL fixed_prio op%0d: req_ready=%b expected 01", k, r);
      end
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [1:0] r;
    idle_inputs();
    do_op(0, 2'b01, 2'b10, 11'd1234, 11'd567, 11'd0, 11'd0, 5, r);
    do_op(0, 2'b10, 2'b00, 11'd0, 11'd0, 11'd77, 11'd88, 0, r);
    vectors++;
    if (r !== 2'b10) begin
      miscompares++; $display("FAIL bp_next_grant: req_ready=%b expected 10", r);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] r;
    apply_reset();
    req_valid[0] = 2'b01;
    req_a[0] = {11'd0, 11'd100};
    req_x[0] = {11'd0, 11'd200};
    rsp_ready[0] = 2'b11;
    @(negedge clk);
    req_valid[0] = 2'b00;
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (busy[0] !== 1'b0 || rsp_valid[0] !== 2'b00) begin
      miscompares++; $display("FAIL reset_calc: busy=%b rsp_valid=%b expected 0 00", busy[0], rsp_valid[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    vectors++;
    if (rsp_valid[0] !== 2'b00 || op_count0 !== 16'd0) begin
      miscompares++; $display("FAIL reset_calc_after: rsp_valid=%b op_count=%0d expected 00 0", rsp_valid[0], op_count0);
    end
    req_valid[0] = 2'b10;
    req_a[0] = {11'd5, 11'd0};
    req_x[0] = {11'd6, 11'd0};
    rsp_ready[0] = 2'b00;
    @(negedge clk);
    req_valid[0] = 2'b00;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (rsp_valid[0] !== 2'b00 || rsp_p[0] !== 22'd0) begin
      miscompares++; $display("FAIL reset_resp: rsp_valid=%b rsp_p=%h expected 00 0", rsp_valid[0], rsp_p[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    do_op(0, 2'b01, 2'b00, 11'd100, 11'd200, 11'd0, 11'd0, 0, r);
  endtask

  task automatic test_edges();
    logic [1:0]  r;
    logic [10:0] ea [3];
    logic [10:0] ex [3];
    ea = '{11'd0, 11'd1, 11'd1024};
    ex = '{11'd2047, 11'd1, 11'd2};
    idle_inputs();
    for (int k = 0; k < 3; k++)
      do_op(0, 2'($urandom_range(1, 3)), 2'b00, ea[k], ex[k], ea[k], ex[k], 0, r);
    apply_reset();
    for (int k = 0; k < 16; k++)
      do_op(1, 2'($urandom_range(1, 3)), 2'b00, 11'($urandom), 11'($urandom),
            11'($urandom), 11'($urandom), 0, r);
    vectors++;
    if (op_count1 !== 4'd0) begin
      miscompares++; $display("FAIL count_wrap: op_count=%0d expected 0", op_count1);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] r;
    idle_inputs();
    for (int k = 0; k < 40; k++)
      do_op(0, 2'($urandom_range(1, 3)), 2'($urandom), 11'($urandom), 11'($urandom),
            11'($urandom), 11'($urandom), $urandom_range(0, 3), r);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    for (int d = 0; d < 2; d++) begin
      req_a[d] = '0;
      req_x[d] = '0;
    end
    model_reset();
    @(negedge clk);
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_reset_mid();
    test_edges();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
